// File: rtl/intersection_phase_scheduler.sv
// Four-approach signal phase scheduler: sensor-driven round-robin green with
// min/max dwell, yellow and all-red clearance on every handover, emergency preemption.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALL_RED_T = 2,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [3:0]  req,
    input  logic        emerg_valid,
    input  logic [1:0]  emerg_id,
    output logic [11:0] light_out,
    output logic [1:0]  active_id,
    output logic [1:0]  phase,
    output logic        emerg_ack
);

    // state  | meaning
    // CLEAR  | all approaches red, clearance dwell before the next green
    // GREEN  | active_id owns the intersection
    // YELLOW | active_id shows yellow before clearance
    typedef enum logic [1:0] {
        CLEAR  = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } phase_t;

    localparam logic [CNT_W-1:0] T_SAT   = '1;
    localparam logic [CNT_W-1:0] T_MIN   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] T_CLEAR = CNT_W'(ALL_RED_T);

    phase_t           state;
    phase_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] elapsed;
    logic [1:0]       id_nxt;
    logic [1:0]       rr_pick;
    logic [1:0]       rr_idx;
    logic             rr_found;
    logic [3:0]       other;

    function automatic logic [11:0] lamps(input phase_t p, input logic [1:0] id);
        logic [2:0] code;
        lamps = 12'h924;
        code  = (p == GREEN) ? 3'b001 : 3'b010;
        if (p != CLEAR) begin
            case (id)
                2'd0: lamps[2:0]  = code;
                2'd1: lamps[5:3]  = code;
                2'd2: lamps[8:6]  = code;
                default: lamps[11:9] = code;
            endcase
        end
    endfunction

    // Ticks elapsed in the current state, including this cycle's tick.
    assign elapsed = (timer == T_SAT) ? T_SAT : timer + CNT_W'(1);
    assign other   = req & ~(4'b0001 << active_id);
    assign phase   = state;

    // Search starts after the current owner and ends on it; no request rests on 0.
    always_comb begin
        rr_pick  = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = active_id + 2'(k);
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = active_id;
        case (state)
            CLEAR: begin
                if (tick && elapsed == T_CLEAR) begin
                    state_nxt = GREEN;
                    id_nxt    = emerg_valid ? emerg_id : rr_pick;
                end
            end
            GREEN: begin
                // An emergency for the owner freezes the green, max-out included.
                if (emerg_valid) begin
                    if (emerg_id != active_id) state_nxt = YELLOW;
                end else if (tick && other != 4'd0 &&
                             ((elapsed >= T_MIN && !req[active_id]) || elapsed >= T_MAX)) begin
                    state_nxt = YELLOW;
                end
            end
            YELLOW: begin
                if (tick && elapsed == T_YEL) state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            timer     <= '0;
            active_id <= 2'd0;
            light_out <= 12'h924;
            emerg_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            active_id <= id_nxt;
            if (state_nxt != state) timer <= '0;
            else if (tick)          timer <= elapsed;
            light_out <= lamps(state_nxt, id_nxt);
            emerg_ack <= (state_nxt == GREEN) && emerg_valid && (emerg_id == id_nxt);
        end
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: lamp codes, dwell timing,
// round-robin order, emergency preemption and mid-yellow reset.
module tb_intersection_phase_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [3:0]  req;
    logic        emerg_valid;
    logic [1:0]  emerg_id;
    logic [11:0] light_out;
    logic [1:0]  active_id;
    logic [1:0]  phase;
    logic        emerg_ack;

    int total = 0;
    int bad   = 0;
    int div     = 1;
    int div_cnt = 0;

    intersection_phase_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_id    (emerg_id),
        .light_out   (light_out),
        .active_id   (active_id),
        .phase       (phase),
        .emerg_ack   (emerg_ack)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; tick fires once every div cycles; sample 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick    = (div_cnt == 0);
            div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] e_light, input logic [1:0] e_id,
                       input logic [1:0] e_ph, input logic e_ack);
        logic [16:0] obs;
        logic [16:0] exp_v;
        obs   = {light_out, active_id, phase, emerg_ack};
        exp_v = {e_light, e_id, e_ph, e_ack};
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: light=%h id=%0d ph=%0d ack=%0b, expected light=%h id=%0d ph=%0d ack=%0b",
                   tag, light_out, active_id, phase, emerg_ack, e_light, e_id, e_ph, e_ack);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b1; req = 4'b0000; emerg_valid = 1'b0; emerg_id = 2'd0;

        // 1: reset, two clearance ticks, rest on approach 0
        step(2);
        chk("reset", 12'h924, 2'd0, 2'b00, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk("clear_1", 12'h924, 2'd0, 2'b00, 1'b0);
        step(1);
        chk("rest_green0", 12'h921, 2'd0, 2'b01, 1'b0);
        step(12);
        chk("rest_hold", 12'h921, 2'd0, 2'b01, 1'b0);

        // 2: gap-out to approach 2
        req = 4'b0100;
        step(1);
        chk("gap_yellow0", 12'h922, 2'd0, 2'b10, 1'b0);
        step(3);
        chk("yellow0_end", 12'h922, 2'd0, 2'b10, 1'b0);
        step(1);
        chk("clear_a", 12'h924, 2'd0, 2'b00, 1'b0);
        step(1);
        chk("clear_b", 12'h924, 2'd0, 2'b00, 1'b0);
        step(1);
        chk("green2", 12'h864, 2'd2, 2'b01, 1'b0);

        // 3: min-green gap-out from 2, then max-out from 0
        req = 4'b0011;
        step(7);
        chk("min_hold2", 12'h864, 2'd2, 2'b01, 1'b0);
        step(1);
        chk("min_yellow2", 12'h8A4, 2'd2, 2'b10, 1'b0);
        step(6);
        chk("green0_rr", 12'h921, 2'd0, 2'b01, 1'b0);
        step(31);
        chk("max_hold", 12'h921, 2'd0, 2'b01, 1'b0);
        step(1);
        chk("max_yellow", 12'h922, 2'd0, 2'b10, 1'b0);
        step(4);
        chk("max_clear", 12'h924, 2'd0, 2'b00, 1'b0);
        step(2);
        chk("green1", 12'h90C, 2'd1, 2'b01, 1'b0);

        // 4: round-robin order 1 -> 2 -> 3 -> 0 (wrap)
        req = 4'b1101;
        step(8);
        chk("yellow1", 12'h914, 2'd1, 2'b10, 1'b0);
        step(6);
        chk("rr_green2", 12'h864, 2'd2, 2'b01, 1'b0);
        req = 4'b1001;
        step(8);
        chk("yellow2", 12'h8A4, 2'd2, 2'b10, 1'b0);
        step(6);
        chk("rr_green3", 12'h324, 2'd3, 2'b01, 1'b0);
        step(32);
        chk("yellow3", 12'h524, 2'd3, 2'b10, 1'b0);
        step(6);
        chk("rr_wrap0", 12'h921, 2'd0, 2'b01, 1'b0);

        // 5: slow ticks, emergency for approach 3 preempts green 0
        req = 4'b0000; div = 10; div_cnt = 0;
        step(30);
        chk("slow_hold0", 12'h921, 2'd0, 2'b01, 1'b0);
        emerg_valid = 1'b1; emerg_id = 2'd3;
        step(1);
        chk("preempt_yel", 12'h922, 2'd0, 2'b10, 1'b0);
        step(39);
        chk("preempt_yel_hold", 12'h922, 2'd0, 2'b10, 1'b0);
        step(1);
        chk("preempt_clear", 12'h924, 2'd0, 2'b00, 1'b0);
        step(20);
        chk("emerg_green3", 12'h324, 2'd3, 2'b01, 1'b1);
        req = 4'b0001;
        step(400);
        chk("emerg_no_max", 12'h324, 2'd3, 2'b01, 1'b1);

        // 6: release emergency, reset in the middle of yellow
        emerg_valid = 1'b0; div = 1; div_cnt = 0;
        step(1);
        chk("post_emerg_yel", 12'h524, 2'd3, 2'b10, 1'b0);
        step(1);
        rst_n = 1'b0; emerg_valid = 1'b1; emerg_id = 2'd2;
        step(1);
        chk("mid_yel_reset", 12'h924, 2'd0, 2'b00, 1'b0);
        rst_n = 1'b1; emerg_valid = 1'b0; req = 4'b0000;
        step(1);
        chk("rst_clear_1", 12'h924, 2'd0, 2'b00, 1'b0);
        step(1);
        chk("rst_green0", 12'h921, 2'd0, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Four-approach signal scheduler that replaces the fixed two-road sequencer. It grants green to one approach at a time using vehicle-sensor requests, round-robin fairness and tick-based min/max green timing. Every handover passes through a yellow interval and an all-red clearance. An emergency request preempts the current phase. It sits between the sensor/tick front end and the lamp drivers.

Parameters:
MIN_GREEN, 8, minimum green dwell in ticks (>=1)
MAX_GREEN, 32, green dwell after which a contested green is forced off (>=MIN_GREEN, <=63)
YELLOW_T, 4, yellow dwell in ticks (>=1)
ALL_RED_T, 2, all-red clearance in ticks (>=1)
CNT_W, 6, dwell timer width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
tick  in  1  one-cycle timing strobe; all dwell counting happens only on cycles where tick=1
req  in  4  level vehicle-presence sensor, one bit per approach
emerg_valid  in  1  emergency preemption request (level)
emerg_id  in  2  approach index the emergency vehicle needs
light_out  out  12  per-approach lamp code at bits [3i+2:3i]: red=100, yellow=010, green=001
active_id  out  2  approach currently owning the phase
phase  out  2  current state: CLEAR=00, GREEN=01, YELLOW=10
emerg_ack  out  1  high while GREEN, active_id==emerg_id and emerg_valid

Behaviour:
- Clock and reset: clk is the clock. rst_n is synchronous and active-low. Reset drives phase=CLEAR, timer=0, active_id=0, light_out=12'h924 (all red) and emerg_ack=0. Reset asserted in any state, mid-dwell included, behaves the same way on the next clk edge.
- Timer: cleared on every state entry; increments on tick and saturates at 2^CNT_W-1. Let e = timer+1 on a tick cycle (ticks elapsed including the current one).
- Outputs: registered and derived from phase/active_id only. Non-active approaches always show red. In CLEAR all four approaches show red.
- CLEAR: on a tick with e==ALL_RED_T, move to GREEN and load active_id with the selected approach:
  - if emerg_valid, select emerg_id;
  - else round-robin, searching active_id+1, +2, +3, then active_id itself, mod 4, for the first req bit set;
  - if req==0, select approach 0 (rest-on-main).
- GREEN, emergency preemption: if emerg_valid and emerg_id!=active_id, go to YELLOW on the next clk edge regardless of tick or MIN_GREEN. If emerg_id==active_id, green holds and MAX_GREEN is ignored.
- GREEN, other exits: evaluated only on tick cycles, and only when another approach is requesting (other = req with the active bit masked, nonzero).
  - Gap-out: e>=MIN_GREEN and req[active_id]==0 → YELLOW.
  - Max-out: e>=MAX_GREEN → YELLOW.
  - With no competing request, green holds indefinitely.
- YELLOW: on a tick with e==YELLOW_T, go to CLEAR. Emergency does not shorten yellow or clearance.
- Simultaneous events: emergency arrival on a tick cycle is still taken on that edge. A request withdrawn during YELLOW/CLEAR is resampled at CLEAR exit. Changing emerg_id mid-GREEN preempts as above.
- Ticks: a tick during reset is ignored. tick tied high makes each tick one clk cycle.
- Latency: state changes take effect on the clk edge where the condition is true; light_out updates in the same cycle as phase.

Test Plan:
1. tick=1, req=0, reset released → light_out=0x924 for 2 cycles, then 0x921 (approach 0 green) held indefinitely, phase=01.
2. Resting green on 0 for >8 ticks, then req=4'b0100 → next tick YELLOW (0x922) for 4 ticks, CLEAR (0x924) for 2 ticks, then 0x864 with active_id=2.
3. Max-out: req=4'b0011 held from approach-0 green entry → green exactly 32 ticks, then yellow, clear, active_id=1.
4. Round-robin: active_id=1, req=4'b1101 at CLEAR exit → active_id=2. Next cycle with req=4'b1001 → active_id=3, then active_id=0.
5. Emergency: tick gated to 1-in-10 cycles, approach 0 at e=3, emerg_valid=1 with emerg_id=3 → YELLOW next clk edge. After yellow and clear, active_id=3 and emerg_ack=1. MAX_GREEN ignored while emerg_valid holds.
6. rst_n pulsed low for one cycle mid-YELLOW → next edge light_out=0x924, phase=00, timer=0, emerg_ack=0. After release, sequence repeats as in scenario 1.
